// File: rtl/fifo_write_status.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_status
// Purpose  : FIFO write pointer, occupancy counter and registered status flags.
//            Optional sticky overflow/underflow: FIFO_STATUS_STICKY_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_status #(
    parameter int PTR_LENGTH      = 5,
    parameter int LENGTH          = 4,
    parameter int ALMOST_FULL_TH  = 3,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write,
    input  logic                  fifo_read,
    input  logic                  err_clr,
    output logic [PTR_LENGTH-1:0] wptr,
    output logic                  fifo_write,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_LENGTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_LENGTH-1:0] c_LAST_PTR = PTR_LENGTH'(LENGTH - 1);
    localparam logic [PTR_LENGTH:0]   c_LENGTH   = (PTR_LENGTH + 1)'(LENGTH);
    localparam logic [PTR_LENGTH:0]   c_AF_TH    = (PTR_LENGTH + 1)'(ALMOST_FULL_TH);
    localparam logic [PTR_LENGTH:0]   c_AE_TH    = (PTR_LENGTH + 1)'(ALMOST_EMPTY_TH);

    logic [PTR_LENGTH-1:0] wptr_q, wptr_d;
    logic [PTR_LENGTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  w_accept;

    // Conservative full policy: a same-cycle read never frees room for a write.
    assign w_accept = write & ~full_q;

    always_comb begin
        wptr_d  = wptr_q;
        count_d = count_q;
        if (w_accept) begin
            wptr_d = (wptr_q == c_LAST_PTR) ? '0 : wptr_q + 1'b1;
        end
        if (w_accept && !fifo_read && (count_q != c_LENGTH)) begin
            count_d = count_q + 1'b1;
        end else if (!w_accept && fifo_read && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
        full_d   = (count_d == c_LENGTH);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= c_AF_TH);
        aempty_d = (count_d <= c_AE_TH);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

`ifdef FIFO_STATUS_STICKY_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Set wins over a same-cycle clear so a recurring violation is never lost.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (write && full_q) begin
            ovf_d = 1'b1;
        end
        if (fifo_read && empty_q) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

    assign wptr         = wptr_q;
    assign fifo_write   = w_accept;
    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_status.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_status
// Purpose  : Directed, table-driven self-checking bench for fifo_write_status.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_status;

`ifdef FIFO_STATUS_STICKY_ERR_EN
    localparam bit c_STICKY = 1'b1;
`else
    localparam bit c_STICKY = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       write;
    logic       fifo_read;
    logic       err_clr;
    logic [4:0] wptr;
    logic       fifo_write;
    logic       fifo_full;
    logic       fifo_empty;
    logic       almost_full;
    logic       almost_empty;
    logic [5:0] count;
    logic       overflow;
    logic       underflow;

    int n_cmp;
    int n_bad;

    fifo_write_status #(
        .PTR_LENGTH      (5),
        .LENGTH          (4),
        .ALMOST_FULL_TH  (3),
        .ALMOST_EMPTY_TH (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .write        (write),
        .fifo_read    (fifo_read),
        .err_clr      (err_clr),
        .wptr         (wptr),
        .fifo_write   (fifo_write),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       wr;
        logic       rd;
        logic       clr;
        logic       fw;
        logic [4:0] wptr;
        logic [5:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ov;
        logic       uf;
    } vec_t;

    vec_t tbl [28];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // rst_n wr rd clr | fw wptr cnt full empty af ae ov uf
        tbl[0]  = '{0,1,0,0, 1, 5'd0, 6'd0, 0,1,0,1, 0,0};
        tbl[1]  = '{1,1,0,0, 1, 5'd1, 6'd1, 0,0,0,1, 0,0};
        tbl[2]  = '{1,1,0,0, 1, 5'd2, 6'd2, 0,0,0,0, 0,0};
        tbl[3]  = '{1,1,0,0, 1, 5'd3, 6'd3, 0,0,1,0, 0,0};
        tbl[4]  = '{1,1,0,0, 1, 5'd0, 6'd4, 1,0,1,0, 0,0};
        tbl[5]  = '{1,1,0,0, 0, 5'd0, 6'd4, 1,0,1,0, 1,0};
        tbl[6]  = '{1,1,1,0, 0, 5'd0, 6'd3, 0,0,1,0, 1,0};
        tbl[7]  = '{1,1,0,1, 1, 5'd1, 6'd4, 1,0,1,0, 0,0};
        tbl[8]  = '{1,0,1,0, 0, 5'd1, 6'd3, 0,0,1,0, 0,0};
        tbl[9]  = '{1,0,1,0, 0, 5'd1, 6'd2, 0,0,0,0, 0,0};
        tbl[10] = '{1,1,1,0, 1, 5'd2, 6'd2, 0,0,0,0, 0,0};
        tbl[11] = '{1,1,1,0, 1, 5'd3, 6'd2, 0,0,0,0, 0,0};
        tbl[12] = '{1,1,1,0, 1, 5'd0, 6'd2, 0,0,0,0, 0,0};
        tbl[13] = '{1,1,1,0, 1, 5'd1, 6'd2, 0,0,0,0, 0,0};
        tbl[14] = '{1,1,1,0, 1, 5'd2, 6'd2, 0,0,0,0, 0,0};
        tbl[15] = '{1,1,1,0, 1, 5'd3, 6'd2, 0,0,0,0, 0,0};
        tbl[16] = '{1,0,1,0, 0, 5'd3, 6'd1, 0,0,0,1, 0,0};
        tbl[17] = '{1,0,1,0, 0, 5'd3, 6'd0, 0,1,0,1, 0,0};
        tbl[18] = '{1,0,1,0, 0, 5'd3, 6'd0, 0,1,0,1, 0,1};
        tbl[19] = '{1,0,1,1, 0, 5'd3, 6'd0, 0,1,0,1, 0,1};
        tbl[20] = '{1,0,0,1, 0, 5'd3, 6'd0, 0,1,0,1, 0,0};
        tbl[21] = '{1,0,1,0, 0, 5'd3, 6'd0, 0,1,0,1, 0,1};
        tbl[22] = '{1,1,0,0, 1, 5'd0, 6'd1, 0,0,0,1, 0,1};
        tbl[23] = '{1,1,0,0, 1, 5'd1, 6'd2, 0,0,0,0, 0,1};
        tbl[24] = '{1,1,0,0, 1, 5'd2, 6'd3, 0,0,1,0, 0,1};
        tbl[25] = '{1,1,1,0, 1, 5'd3, 6'd3, 0,0,1,0, 0,1};
        tbl[26] = '{0,1,0,0, 1, 5'd0, 6'd0, 0,1,0,1, 0,0};
        tbl[27] = '{1,0,0,0, 0, 5'd0, 6'd0, 0,1,0,1, 0,0};

        reset_n   = 1'b0;
        write     = 1'b0;
        fifo_read = 1'b0;
        err_clr   = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 28; i++) begin
            reset_n   = tbl[i].rst_n;
            write     = tbl[i].wr;
            fifo_read = tbl[i].rd;
            err_clr   = tbl[i].clr;
            #1;
            chk("fifo_write", i, 32'(fifo_write), 32'(tbl[i].fw));
            tick();
            chk("wptr",         i, 32'(wptr),         32'(tbl[i].wptr));
            chk("count",        i, 32'(count),        32'(tbl[i].cnt));
            chk("fifo_full",    i, 32'(fifo_full),    32'(tbl[i].full));
            chk("fifo_empty",   i, 32'(fifo_empty),   32'(tbl[i].empty));
            chk("almost_full",  i, 32'(almost_full),  32'(tbl[i].af));
            chk("almost_empty", i, 32'(almost_empty), 32'(tbl[i].ae));
            chk("overflow",     i, 32'(overflow),     32'(c_STICKY ? tbl[i].ov : 1'b0));
            chk("underflow",    i, 32'(underflow),    32'(c_STICKY ? tbl[i].uf : 1'b0));
        end

        // Fill to full, read once, and confirm writes reopen the very next cycle.
        write     = 1'b1;
        fifo_read = 1'b0;
        err_clr   = 1'b0;
        repeat (4) tick();
        chk("seq_full",  100, 32'(fifo_full), 32'd1);
        chk("seq_wptr0", 100, 32'(wptr),      32'd0);
        write     = 1'b0;
        fifo_read = 1'b1;
        tick();
        chk("seq_cnt3",  101, 32'(count),     32'd3);
        chk("seq_nfull", 101, 32'(fifo_full), 32'd0);
        write     = 1'b1;
        fifo_read = 1'b0;
        #1;
        chk("seq_fw_reopen", 102, 32'(fifo_write), 32'd1);
        tick();
        chk("seq_cnt4",  103, 32'(count),      32'd4);
        chk("seq_wptr1", 103, 32'(wptr),       32'd1);
        chk("seq_fw_blk", 103, 32'(fifo_write), 32'd0);

        write = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
